// File: rtl/cp0_intc.sv
// Coprocessor-0 register file and interrupt controller for the multi-cycle MIPS core:
// synchronised level/edge interrupt lines, SR/Cause/EPC/PRId and a single request to the controller.
module cp0_intc #(
    parameter int                   NUM_HWINT   = 6,
    parameter logic [NUM_HWINT-1:0] EDGE_MASK   = '0,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [31:0]          PRID        = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 exc_ov,
    input  logic                 take,
    input  logic [31:0]          epc_in,
    input  logic                 we,
    input  logic [4:0]           sel,
    input  logic [31:0]          wdata,
    input  logic                 eret,
    output logic [31:0]          rdata,
    output logic                 int_req,
    output logic [4:0]           exc_code,
    output logic [31:0]          epc_out
);

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_INT  = 5'd0;

    logic [NUM_HWINT-1:0] s;
    logic [NUM_HWINT-1:0] sp;
    logic [NUM_HWINT-1:0] ip;
    logic [NUM_HWINT-1:0] ip_next;
    logic [NUM_HWINT-1:0] im;
    logic                 ie;
    logic                 exl;
    logic [4:0]           exc_q;
    logic [29:0]          epc_q;
    logic                 sw_write;
    logic                 wr_sr;
    logic                 wr_cause;
    logic                 wr_epc;
    logic                 pend;
    logic                 unused_epc_lsb;

    // An mtc0 coinciding with take is dropped entirely, including edge-IP clears.
    assign sw_write       = we & ~take;
    assign wr_sr          = sw_write & (sel == SEL_SR);
    assign wr_cause       = sw_write & (sel == SEL_CAUSE);
    assign wr_epc         = sw_write & (sel == SEL_EPC);
    assign unused_epc_lsb = ^epc_in[1:0];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = hwint;
        end else begin : g_sync
            logic [NUM_HWINT-1:0] chain [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int j = 0; j < SYNC_STAGES; j++) chain[j] <= '0;
                end else begin
                    chain[0] <= hwint;
                    for (int j = 1; j < SYNC_STAGES; j++) chain[j] <= chain[j-1];
                end
            end

            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

    // Edge bits: a new rising edge beats a same-cycle software clear.
    always_comb begin
        ip_next = '0;
        for (int i = 0; i < NUM_HWINT; i++) begin
            if (EDGE_MASK[i]) begin
                ip_next[i] = (s[i] & ~sp[i]) | (ip[i] & ~(wr_cause & ~wdata[10+i]));
            end else begin
                ip_next[i] = s[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
            ip <= '0;
        end else begin
            sp <= s;
            ip <= ip_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im    <= '0;
            ie    <= 1'b0;
            exl   <= 1'b0;
            exc_q <= '0;
            epc_q <= '0;
        end else if (take) begin
            exl   <= 1'b1;
            exc_q <= exc_code;
            epc_q <= epc_in[31:2];
        end else begin
            if (wr_sr) begin
                im  <= wdata[9+NUM_HWINT:10];
                exl <= wdata[1];
                ie  <= wdata[0];
            end else if (eret) begin
                exl <= 1'b0;
            end
            if (wr_epc) begin
                epc_q <= wdata[31:2];
            end
        end
    end

    assign pend     = (|(ip & im)) & ie & ~exl;
    assign int_req  = exc_ov | pend;
    assign exc_code = exc_ov ? CODE_OV : CODE_INT;
    assign epc_out  = {epc_q, 2'b00};

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_SR: begin
                rdata[9+NUM_HWINT:10] = im;
                rdata[1]              = exl;
                rdata[0]              = ie;
            end
            SEL_CAUSE: begin
                rdata[9+NUM_HWINT:10] = ip;
                rdata[6:2]            = exc_q;
            end
            SEL_EPC:  rdata = {epc_q, 2'b00};
            SEL_PRID: rdata = PRID;
            default:  rdata = '0;
        endcase
    end

endmodule
